// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer family.
package demux_pkg;

    localparam int DEF_SEL_W  = 4;
    localparam int DEF_N      = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [32:0] max_v;
        max_v = (33'd1 << width) - 33'd1;
        return ({1'b0, cnt} >= max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Parametrised binary-to-one-hot decoder with enable and out-of-range flag.
module onehot_dec #(
    parameter int SEL_W = 4,
    parameter int N     = 16
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     onehot,
    output logic             oob
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (32'(sel) == i);
        end
    end

    assign oob = en && (32'(sel) >= N);

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer: holds one beat until every targeted
// channel has taken it, with broadcast mode and out-of-range drop accounting.
module demux_stream
    import demux_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    input  logic [DATA_W-1:0] in_data,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err_sel,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              err_clr
);

    logic [N-1:0]      pend;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [N-1:0] sel_hot;
    logic [N-1:0] tgt;
    logic         sel_oob;
    logic         acc;
    logic         drop;

    onehot_dec #(
        .SEL_W (SEL_W),
        .N     (N)
    ) u_dec (
        .sel    (in_sel),
        .en     (~in_bcast),
        .onehot (sel_hot),
        .oob    (sel_oob)
    );

    // Ready as soon as every still-pending channel is accepting this cycle,
    // which lets a new beat overlap the final drain.
    assign in_ready = ((pend & ~out_ready) == '0);
    assign acc      = in_valid & in_ready;
    assign tgt      = in_bcast ? {N{1'b1}} : sel_hot;
    assign drop     = acc & sel_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            data_q <= '0;
        end else if (acc) begin
            pend   <= tgt;
            data_q <= in_data;
        end else begin
            pend   <= pend & ~out_ready;
        end
    end

    // A drop in the same cycle as a clear still records that drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else if (drop) begin
            err_q <= 1'b1;
            cnt_q <= err_clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end else if (err_clr) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end
    end

    assign out_valid = pend;
    assign out_data  = data_q;
    assign busy      = |pend;
    assign err_sel   = err_q;
    assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Randomised and directed bench for demux_stream: a 16-channel instance and a
// 12-channel instance with a 2-bit drop counter share one stimulus stream.
module tb_demux_stream;

    localparam int NA = 16;
    localparam int NB = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bcast = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  in_sel = '0;
    logic [7:0]  in_data = '0;
    logic [15:0] out_ready = '0;

    logic        in_ready_a, busy_a, err_a;
    logic [15:0] ov_a;
    logic [7:0]  od_a, cnt_a;
    logic        in_ready_b, busy_b, err_b;
    logic [11:0] ov_b;
    logic [7:0]  od_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    demux_stream #(.SEL_W(4), .N(NA), .DATA_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .busy(busy_a), .err_sel(err_a), .drop_cnt(cnt_a), .err_clr(err_clr)
    );

    demux_stream #(.SEL_W(4), .N(NB), .DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready[11:0]), .out_data(od_b),
        .busy(busy_b), .err_sel(err_b), .drop_cnt(cnt_b), .err_clr(err_clr)
    );

    // Reference model: per instance, per channel, the beats still owed to that consumer.
    logic [7:0] expq [2][16][$];
    bit         m_err [2];
    int         m_cnt [2];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) expq[k][i].delete();
            m_err[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    // Compare one instance against the model, then advance the model by the
    // handshakes and acceptance the currently driven inputs will cause.
    task automatic checkStep(input int inst);
        int          n;
        int          cmax;
        string       p;
        logic [15:0] obs_v;
        logic [7:0]  obs_d;
        logic [7:0]  obs_c;
        logic        obs_r, obs_b, obs_e;
        logic [15:0] exp_v;
        logic        exp_r;
        logic [7:0]  exp_d;
        bit          any;

        n    = (inst == 1) ? NB : NA;
        cmax = (inst == 1) ? 3 : 255;
        p    = (inst == 1) ? "b" : "a";
        if (inst == 1) begin
            obs_v = {4'b0, ov_b}; obs_d = od_b; obs_c = {6'b0, cnt_b};
            obs_r = in_ready_b; obs_b = busy_b; obs_e = err_b;
        end else begin
            obs_v = ov_a; obs_d = od_a; obs_c = cnt_a;
            obs_r = in_ready_a; obs_b = busy_a; obs_e = err_a;
        end

        exp_v = '0;
        exp_r = 1'b1;
        exp_d = '0;
        any   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (expq[inst][i].size() > 0) begin
                exp_v[i] = 1'b1;
                exp_d    = expq[inst][i][0];
                any      = 1'b1;
                if (!out_ready[i]) exp_r = 1'b0;
            end
        end

        checkOutput({p, ".out_valid"}, obs_v, exp_v);
        checkOutput({p, ".in_ready"}, obs_r, exp_r);
        checkOutput({p, ".busy"}, obs_b, any);
        checkOutput({p, ".err_sel"}, obs_e, m_err[inst]);
        checkOutput({p, ".drop_cnt"}, obs_c, m_cnt[inst]);
        if (any) checkOutput({p, ".out_data"}, obs_d, exp_d);

        for (int i = 0; i < n; i++) begin
            if (expq[inst][i].size() > 0 && out_ready[i]) void'(expq[inst][i].pop_front());
        end

        if (in_valid && exp_r && !in_bcast && int'(in_sel) >= n) begin
            m_err[inst] = 1'b1;
            m_cnt[inst] = err_clr ? 1 : ((m_cnt[inst] < cmax) ? m_cnt[inst] + 1 : cmax);
        end else begin
            if (in_valid && exp_r) begin
                if (in_bcast) begin
                    for (int i = 0; i < n; i++) expq[inst][i].push_back(in_data);
                end else begin
                    expq[inst][int'(in_sel)].push_back(in_data);
                end
            end
            if (err_clr) begin
                m_err[inst] = 1'b0;
                m_cnt[inst] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] sel, input logic bc,
                                 input logic [7:0] d, input logic [15:0] rdy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_bcast  = bc;
        in_data   = d;
        out_ready = rdy;
        err_clr   = clr;
        #1;
        checkStep(0);
        checkStep(1);
    endtask

    initial begin
        clearModel();

        // Reset and idle
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst.out_valid", ov_a, 0);
        checkOutput("rst.in_ready", in_ready_a, 1);
        checkOutput("rst.out_data", od_a, 0);
        checkOutput("rst.drop_cnt", cnt_a, 0);
        checkOutput("rst.err_sel", err_a, 0);
        checkOutput("rst.b_out_valid", ov_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unicast streaming to every channel at full rate
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 8'hA0 + 8'(i), 16'hFFFF, 1'b0);
            checkOutput("uni.in_ready", in_ready_a, 1);
            if (i > 0) checkOutput("uni.onehot", ov_a, 32'h1 << (i - 1));
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("uni.last", ov_a, 16'h8000);
        checkOutput("uni.last_data", od_a, 8'hAF);

        // Backpressure, then overlap of final drain with the next beat
        applyStimulus(1'b1, 4'd5, 1'b0, 8'h3C, 16'hFFFF, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 4'd9, 1'b0, 8'h55, 16'h0000, 1'b0);
            checkOutput("bp.hold_valid", ov_a, 16'h0020);
            checkOutput("bp.hold_data", od_a, 8'h3C);
            checkOutput("bp.stall", in_ready_a, 0);
        end
        applyStimulus(1'b1, 4'd9, 1'b0, 8'h55, 16'h0020, 1'b0);
        checkOutput("bp.release", in_ready_a, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'h0000, 1'b0);
        checkOutput("bp.next_valid", ov_a, 16'h0200);
        checkOutput("bp.next_data", od_a, 8'h55);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);

        // Broadcast accepted by three staggered groups
        applyStimulus(1'b1, 4'd0, 1'b1, 8'hFF, 16'hFFFF, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'h000F, 1'b0);
        checkOutput("bc.grp0_ready", in_ready_a, 0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'h0FF0, 1'b0);
        checkOutput("bc.grp1_ready", in_ready_a, 0);
        checkOutput("bc.grp1_valid", ov_a, 16'hFFF0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hF000, 1'b0);
        checkOutput("bc.grp2_ready", in_ready_a, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("bc.done", ov_a, 0);

        // Out-of-range drops on the 12-channel instance
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'd13, 1'b0, 8'h11, 16'hFFFF, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("oob.valid", ov_b, 0);
        checkOutput("oob.err", err_b, 1);
        checkOutput("oob.cnt3", cnt_b, 3);
        for (int c = 0; c < 2; c++) applyStimulus(1'b1, 4'd13, 1'b0, 8'h11, 16'hFFFF, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("oob.sat", cnt_b, 3);

        // Clear alone, then clear colliding with a drop
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("clr.err", err_b, 0);
        checkOutput("clr.cnt", cnt_b, 0);
        applyStimulus(1'b1, 4'd14, 1'b0, 8'h22, 16'hFFFF, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        checkOutput("clrdrop.err", err_b, 1);
        checkOutput("clrdrop.cnt", cnt_b, 1);

        // Asynchronous reset in the middle of a pending broadcast
        applyStimulus(1'b1, 4'd0, 1'b1, 8'h77, 16'hFFFF, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.valid", ov_a, 0);
        checkOutput("arst.busy", busy_a, 0);
        checkOutput("arst.ready", in_ready_a, 1);
        checkOutput("arst.data", od_a, 0);
        checkOutput("arst.b_err", err_b, 0);
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 7) == 0, 8'($urandom),
                          16'($urandom | $urandom), $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
